// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-access stage of the RV32I pipeline.
//
// Takes the EX/MEM register outputs and performs byte, half and word loads and
// stores against an internal data RAM that has a configurable access latency.
// It registers the results into the MEM/WB boundary. While a multi-cycle
// access is in flight, a two-state wait FSM holds Stall_M high and feeds
// bubbles into WB.
//
// Parameters:
//   WIDTH   - datapath width. Byte-lane steering assumes 32 bits.
//   ADDR_W  - word-address bits of the internal RAM (2^ADDR_W words).
//   LATENCY - extra wait cycles per access. 0 gives a single-cycle access.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   *_M inputs        - EX/MEM fields (address/ALU result, store data, rd, PC+4,
//                       funct3, RegWrite, ResultSrc, MemWrite)
//   Stall_M           - holds the upstream pipeline registers this cycle
//   MisalignFault_M   - pulse on the completion cycle of a misaligned access
//   *_W outputs       - MEM/WB register contents
//
// Optional feature macro: LSU_MISALIGN_CHECK_EN
//   Defined:   misaligned accesses are detected. The store is dropped, WB gets
//              a bubble, and MisalignFault_M pulses.
//   Undefined: the low address bits are forced to natural alignment, and
//              MisalignFault_M is tied low.

module mem_stage_lsu #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ALUResult_M,
  input  logic [WIDTH-1:0] WriteData_M,
  input  logic [4:0]       Rd_M,
  input  logic [WIDTH-1:0] PCP4_M,
  input  logic [2:0]       funct3_M,
  input  logic             RegWrite_M,
  input  logic [1:0]       ResultSrc_M,
  input  logic             MemWrite_M,
  output logic             Stall_M,
  output logic             MisalignFault_M,
  output logic [WIDTH-1:0] ReadData_W,
  output logic [WIDTH-1:0] ALUResult_W,
  output logic [WIDTH-1:0] PCP4_W,
  output logic [4:0]       Rd_W,
  output logic             RegWrite_W,
  output logic [1:0]       ResultSrc_W
);

  localparam int unsigned NumBytes = WIDTH / 8;
  localparam int unsigned CntW     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned CntInit  = (LATENCY > 0) ? LATENCY - 1 : 0;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic is_load, is_store, access;
  logic done, stall, done_g, stall_g;
  logic sz_byte, sz_half;
  logic misalign, fault;
  logic [1:0] addr_lo;

  assign is_load  = (ResultSrc_M == 2'b01);
  assign is_store = MemWrite_M;
  assign access   = is_load | is_store;

  // Reserved funct3 encodings fall through to word size.
  assign sz_byte = (funct3_M[1:0] == 2'b00);
  assign sz_half = (funct3_M[1:0] == 2'b01);

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = (sz_half && ALUResult_M[0]) ||
                    (!sz_byte && !sz_half && (ALUResult_M[1:0] != 2'b00));
  assign addr_lo  = ALUResult_M[1:0];
`else
  assign misalign = 1'b0;
  always_comb begin
    addr_lo = ALUResult_M[1:0];
    if (sz_half) begin
      addr_lo = {ALUResult_M[1], 1'b0};
    end else if (!sz_byte) begin
      addr_lo = 2'b00;
    end
  end
`endif

  // Wait-state FSM. The access completes in StIdle when LATENCY is 0.
  // Otherwise it completes in StWait once the counter reaches zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (access) begin
          if (LATENCY == 0) begin
            done = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = StWait;
            cnt_d   = CntW'(CntInit);
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          done    = 1'b1;
          state_d = StIdle;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset must silence the combinational outputs, and it must stop a store
  // from landing even while the access inputs are still applied.
  assign done_g  = done & rst_n;
  assign stall_g = stall & rst_n;
  assign fault   = done_g & access & misalign;

  assign Stall_M         = stall_g;
  assign MisalignFault_M = fault;

  // Data RAM. Its contents are deliberately not reset.
  logic [WIDTH-1:0]    mem_q [2**ADDR_W];
  logic [ADDR_W-1:0]   widx;
  logic [WIDTH-1:0]    rword, lane, wdata, load_val;
  logic [NumBytes-1:0] ben;
  logic                we;

  assign widx  = ALUResult_M[ADDR_W+1:2];
  assign rword = mem_q[widx];
  assign we    = done_g & is_store & ~misalign;

  always_comb begin
    wdata = WriteData_M;
    ben   = '1;
    if (sz_byte) begin
      wdata = {NumBytes{WriteData_M[7:0]}};
      ben   = NumBytes'(1) << addr_lo;
    end else if (sz_half) begin
      wdata = {(NumBytes / 2){WriteData_M[15:0]}};
      ben   = NumBytes'(3) << addr_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (ben[b]) begin
          mem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Load formatting: shift the addressed lane down to bit 0, then extend it.
  assign lane = rword >> {addr_lo, 3'b000};

  always_comb begin
    load_val = lane;
    if (sz_byte) begin
      load_val = funct3_M[2] ? {{(WIDTH-8){1'b0}}, lane[7:0]}
                             : {{(WIDTH-8){lane[7]}}, lane[7:0]};
    end else if (sz_half) begin
      load_val = funct3_M[2] ? {{(WIDTH-16){1'b0}}, lane[15:0]}
                             : {{(WIDTH-16){lane[15]}}, lane[15:0]};
    end
  end

  // MEM/WB register.
  logic [WIDTH-1:0] read_data_q, alu_result_q, pcp4_q;
  logic [4:0]       rd_q;
  logic             reg_write_q;
  logic [1:0]       result_src_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data_q  <= '0;
      alu_result_q <= '0;
      pcp4_q       <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      result_src_q <= '0;
    end else if (stall || fault) begin
      read_data_q  <= '0;
      alu_result_q <= '0;
      pcp4_q       <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      result_src_q <= '0;
    end else begin
      read_data_q  <= is_load ? load_val : '0;
      alu_result_q <= ALUResult_M;
      pcp4_q       <= PCP4_M;
      rd_q         <= Rd_M;
      reg_write_q  <= RegWrite_M;
      result_src_q <= ResultSrc_M;
    end
  end

  assign ReadData_W  = read_data_q;
  assign ALUResult_W = alu_result_q;
  assign PCP4_W      = pcp4_q;
  assign Rd_W        = rd_q;
  assign RegWrite_W  = reg_write_q;
  assign ResultSrc_W = result_src_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Testbench for mem_stage_lsu. It runs one LATENCY=0 instance and one
// LATENCY=2 instance (the default). Both instances share the clock and reset.
module tb_mem_stage_lsu;

`ifdef LSU_MISALIGN_CHECK_EN
  localparam bit MisEn = 1'b1;
`else
  localparam bit MisEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] pcp4;
    logic [2:0]  f3;
    logic        rw;
    logic [1:0]  rs;
    logic        mw;
  } m_in_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [31:0] pcp4;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  rs;
  } w_out_t;

  typedef struct {
    string  name;
    m_in_t  i;
    w_out_t e;
  } vec_t;

  m_in_t  in0, in2;
  w_out_t out0, out2;
  logic   stall0, stall2, flt0, flt2;

  logic [31:0] rdata0, alu0, pcp40, rdata2, alu2, pcp42;
  logic [4:0]  rd0, rd2;
  logic        rw0, rw2;
  logic [1:0]  rs0, rs2;

  assign out0 = {rdata0, alu0, pcp40, rd0, rw0, rs0};
  assign out2 = {rdata2, alu2, pcp42, rd2, rw2, rs2};

  mem_stage_lsu #(.WIDTH(32), .ADDR_W(12), .LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .ALUResult_M(in0.alu), .WriteData_M(in0.wd), .Rd_M(in0.rd), .PCP4_M(in0.pcp4),
    .funct3_M(in0.f3), .RegWrite_M(in0.rw), .ResultSrc_M(in0.rs), .MemWrite_M(in0.mw),
    .Stall_M(stall0), .MisalignFault_M(flt0),
    .ReadData_W(rdata0), .ALUResult_W(alu0), .PCP4_W(pcp40),
    .Rd_W(rd0), .RegWrite_W(rw0), .ResultSrc_W(rs0)
  );

  mem_stage_lsu #(.WIDTH(32), .ADDR_W(12), .LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .ALUResult_M(in2.alu), .WriteData_M(in2.wd), .Rd_M(in2.rd), .PCP4_M(in2.pcp4),
    .funct3_M(in2.f3), .RegWrite_M(in2.rw), .ResultSrc_M(in2.rs), .MemWrite_M(in2.mw),
    .Stall_M(stall2), .MisalignFault_M(flt2),
    .ReadData_W(rdata2), .ALUResult_W(alu2), .PCP4_W(pcp42),
    .Rd_W(rd2), .RegWrite_W(rw2), .ResultSrc_W(rs2)
  );

  int checks = 0;
  int failures = 0;

  function automatic m_in_t ld(logic [31:0] a, logic [2:0] f3, logic [4:0] rd);
    return '{alu: a, wd: 32'h0, rd: rd, pcp4: 32'h400, f3: f3, rw: 1'b1, rs: 2'b01, mw: 1'b0};
  endfunction

  function automatic m_in_t st(logic [31:0] a, logic [31:0] wd, logic [2:0] f3);
    return '{alu: a, wd: wd, rd: 5'd0, pcp4: 32'h400, f3: f3, rw: 1'b0, rs: 2'b00, mw: 1'b1};
  endfunction

  function automatic m_in_t op(logic [31:0] a, logic [31:0] p, logic [1:0] rs, logic [4:0] rd);
    return '{alu: a, wd: 32'h0, rd: rd, pcp4: p, f3: 3'b000, rw: 1'b1, rs: rs, mw: 1'b0};
  endfunction

  function automatic w_out_t e_ld(logic [31:0] a, logic [4:0] rd, logic [31:0] d);
    return '{rdata: d, alu: a, pcp4: 32'h400, rd: rd, rw: 1'b1, rs: 2'b01};
  endfunction

  function automatic w_out_t e_st(logic [31:0] a);
    return '{rdata: 32'h0, alu: a, pcp4: 32'h400, rd: 5'd0, rw: 1'b0, rs: 2'b00};
  endfunction

  function automatic w_out_t e_op(logic [31:0] a, logic [31:0] p, logic [1:0] rs, logic [4:0] rd);
    return '{rdata: 32'h0, alu: a, pcp4: p, rd: rd, rw: 1'b1, rs: rs};
  endfunction

  task automatic chk_w(input string nm, input w_out_t act, input w_out_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got rdata=%h alu=%h pcp4=%h rd=%0d rw=%b rs=%b, want rdata=%h alu=%h pcp4=%h rd=%0d rw=%b rs=%b",
               nm, act.rdata, act.alu, act.pcp4, act.rd, act.rw, act.rs,
               exp.rdata, exp.alu, exp.pcp4, exp.rd, exp.rw, exp.rs);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b, want %b", nm, act, exp);
    end
  endtask

  // A LATENCY=2 access: Stall_M is high for two cycles while two bubbles
  // reach WB, and the real result arrives on the third edge.
  task automatic acc2(input string nm, input m_in_t i, input w_out_t e);
    in2 = i;
    #1;
    chk1({nm, " stall c0"}, stall2, 1'b1);
    @(posedge clk); #1;
    chk_w({nm, " bubble1"}, out2, '0);
    chk1({nm, " stall c1"}, stall2, 1'b1);
    @(posedge clk); #1;
    chk_w({nm, " bubble2"}, out2, '0);
    chk1({nm, " stall c2"}, stall2, 1'b0);
    chk1({nm, " fault c2"}, flt2, 1'b0);
    @(posedge clk); #1;
    chk_w({nm, " result"}, out2, e);
  endtask

  vec_t vecs[$];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs.push_back('{"sw 10",     st(32'h10, 32'hDEADBEEF, 3'b010), e_st(32'h10)});
    vecs.push_back('{"lw 10",     ld(32'h10, 3'b010, 5'd5),  e_ld(32'h10, 5'd5, 32'hDEADBEEF)});
    vecs.push_back('{"sw 20",     st(32'h20, 32'h80FF7F01, 3'b010), e_st(32'h20)});
    vecs.push_back('{"lb 23",     ld(32'h23, 3'b000, 5'd1),  e_ld(32'h23, 5'd1, 32'hFFFFFF80)});
    vecs.push_back('{"lbu 23",    ld(32'h23, 3'b100, 5'd2),  e_ld(32'h23, 5'd2, 32'h00000080)});
    vecs.push_back('{"lh 22",     ld(32'h22, 3'b001, 5'd3),  e_ld(32'h22, 5'd3, 32'hFFFF80FF)});
    vecs.push_back('{"lhu 20",    ld(32'h20, 3'b101, 5'd4),  e_ld(32'h20, 5'd4, 32'h00007F01)});
    vecs.push_back('{"sb 21",     st(32'h21, 32'h123456AA, 3'b000), e_st(32'h21)});
    vecs.push_back('{"lw 20",     ld(32'h20, 3'b010, 5'd6),  e_ld(32'h20, 5'd6, 32'h80FFAA01)});
    vecs.push_back('{"add",       op(32'h12345678, 32'h104, 2'b00, 5'd8),
                                  e_op(32'h12345678, 32'h104, 2'b00, 5'd8)});
    vecs.push_back('{"jal",       op(32'h55, 32'h200, 2'b10, 5'd1), e_op(32'h55, 32'h200, 2'b10, 5'd1)});
    vecs.push_back('{"sw 30",     st(32'h30, 32'h11223344, 3'b010), e_st(32'h30)});
    vecs.push_back('{"sh 32",     st(32'h32, 32'hCAFEBEEF, 3'b001), e_st(32'h32)});
    vecs.push_back('{"lw 30",     ld(32'h30, 3'b010, 5'd7),  e_ld(32'h30, 5'd7, 32'hBEEF3344)});
    vecs.push_back('{"lh 32",     ld(32'h32, 3'b001, 5'd9),  e_ld(32'h32, 5'd9, 32'hFFFFBEEF)});
    vecs.push_back('{"lw wrap",   ld(32'h4010, 3'b010, 5'd10), e_ld(32'h4010, 5'd10, 32'hDEADBEEF)});
    vecs.push_back('{"lb 10",     ld(32'h10, 3'b000, 5'd11), e_ld(32'h10, 5'd11, 32'hFFFFFFEF)});
    vecs.push_back('{"lbu 11",    ld(32'h11, 3'b100, 5'd12), e_ld(32'h11, 5'd12, 32'h000000BE)});
    vecs.push_back('{"ld f3=110", ld(32'h30, 3'b110, 5'd13), e_ld(32'h30, 5'd13, 32'hBEEF3344)});
    vecs.push_back('{"st f3=011", st(32'h34, 32'hA5A5A5A5, 3'b011), e_st(32'h34)});
    vecs.push_back('{"lw 34",     ld(32'h34, 3'b010, 5'd14), e_ld(32'h34, 5'd14, 32'hA5A5A5A5)});

    // Reset state. A load is applied during reset, so Stall_M must be held low.
    rst_n = 1'b0;
    in0   = '0;
    in2   = ld(32'h40, 3'b010, 5'd1);
    repeat (2) @(posedge clk);
    #1;
    chk_w("reset out0", out0, '0);
    chk_w("reset out2", out2, '0);
    chk1("reset stall2", stall2, 1'b0);
    chk1("reset fault0", flt0, 1'b0);
    in2   = '0;
    rst_n = 1'b1;

    // LATENCY=0 vector table.
    foreach (vecs[k]) begin
      in0 = vecs[k].i;
      #1;
      chk1({vecs[k].name, " stall"}, stall0, 1'b0);
      chk1({vecs[k].name, " fault"}, flt0, 1'b0);
      @(posedge clk); #1;
      chk_w(vecs[k].name, out0, vecs[k].e);
    end

    // Misaligned SW to 0x22. The word at 0x20 currently holds 0x80FFAA01.
    in0 = st(32'h22, 32'h99887766, 3'b010);
    #1;
    chk1("mis sw fault", flt0, MisEn);
    chk1("mis sw stall", stall0, 1'b0);
    @(posedge clk); #1;
    chk_w("mis sw wb", out0, MisEn ? w_out_t'('0) : e_st(32'h22));
    in0 = '0;
    #1;
    chk1("mis fault pulse end", flt0, 1'b0);
    @(posedge clk); #1;
    in0 = ld(32'h20, 3'b010, 5'd15);
    @(posedge clk); #1;
    chk_w("mis sw ram", out0, e_ld(32'h20, 5'd15, MisEn ? 32'h80FFAA01 : 32'h99887766));
    in0 = ld(32'h22, 3'b010, 5'd16);
    #1;
    chk1("mis lw fault", flt0, MisEn);
    @(posedge clk); #1;
    chk_w("mis lw wb", out0,
          MisEn ? w_out_t'('0) : e_ld(32'h22, 5'd16, 32'h99887766));
    in0 = '0;

    // LATENCY=2 instance: a pass-through op, then back-to-back accesses.
    in2 = op(32'h77, 32'h300, 2'b00, 5'd2);
    #1;
    chk1("l2 add stall", stall2, 1'b0);
    @(posedge clk); #1;
    chk_w("l2 add", out2, e_op(32'h77, 32'h300, 2'b00, 5'd2));
    acc2("l2 sw", st(32'h40, 32'hCAFEF00D, 3'b010), e_st(32'h40));
    acc2("l2 lw", ld(32'h40, 3'b010, 5'd7), e_ld(32'h40, 5'd7, 32'hCAFEF00D));
    in2 = op(32'h99, 32'h304, 2'b10, 5'd3);
    #1;
    chk1("l2 jal stall", stall2, 1'b0);
    @(posedge clk); #1;
    chk_w("l2 jal", out2, e_op(32'h99, 32'h304, 2'b10, 5'd3));

    // Assert reset during the WAIT state of a store. The store must be
    // aborted and the outputs must clear immediately.
    in0 = op(32'hABC, 32'h308, 2'b00, 5'd4);
    in2 = st(32'h40, 32'h0BADBEEF, 3'b010);
    @(posedge clk); #1;
    chk1("rst pre stall2", stall2, 1'b1);
    chk_w("rst pre out0", out0, e_op(32'hABC, 32'h308, 2'b00, 5'd4));
    #2;
    rst_n = 1'b0;
    #1;
    chk1("rst mid stall2", stall2, 1'b0);
    chk_w("rst mid out0", out0, '0);
    chk_w("rst mid out2", out2, '0);
    repeat (2) @(posedge clk);
    #1;
    in0   = '0;
    in2   = '0;
    rst_n = 1'b1;
    acc2("l2 lw after rst", ld(32'h40, 3'b010, 5'd8), e_ld(32'h40, 5'd8, 32'hCAFEF00D));
    in2 = '0;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-access stage of the 5-stage RV32I pipeline: consumes the EX/MEM register outputs, performs byte/half/word loads and stores against an internal data RAM with configurable access latency, and registers the results into the MEM/WB boundary. A small wait-state FSM raises a stall to the hazard unit while a multi-cycle access is in flight, and inserts a bubble into WB until the access completes.

## Interface
- WIDTH, 32, datapath width
- ADDR_W, 12, word-address bits of the internal RAM (2^ADDR_W words)
- LATENCY, 2, extra wait cycles per memory access (0 allowed = single-cycle)

- clk  in  1  pipeline clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- ALUResult_M  in  WIDTH  byte address / ALU result from EX/MEM
- WriteData_M  in  WIDTH  store data (RD2)
- Rd_M  in  5  destination register
- PCP4_M  in  WIDTH  PC+4
- funct3_M  in  3  access size/sign
- RegWrite_M  in  1  register write enable
- ResultSrc_M  in  2  00 ALU, 01 load, 10 PC+4
- MemWrite_M  in  1  store enable
- Stall_M  out  1  hold IF/ID/EX/MEM registers this cycle
- MisalignFault_M  out  1  one-cycle pulse on misaligned access
- ReadData_W, ALUResult_W, PCP4_W  out  WIDTH  MEM/WB data
- Rd_W  out  5; RegWrite_W  out  1; ResultSrc_W  out  2  MEM/WB control

## Operation
- Access = load (ResultSrc_M==01) or store (MemWrite_M==1); other instructions pass straight through, no stall.
- FSM states: IDLE, WAIT. IDLE + access + LATENCY>0 -> WAIT, counter loaded LATENCY-1; WAIT decrements; counter==0 in WAIT -> access completes, return to IDLE. LATENCY==0: access completes in IDLE, WAIT never entered.
- Stall_M = 1 in IDLE when starting an access with LATENCY>0, and in WAIT until the completion cycle; 0 on completion cycle.
- Contract: upstream holds all *_M inputs stable while Stall_M=1.
- Completion cycle: store writes RAM at that clock edge; load reads RAM word at ALUResult_M[ADDR_W+1:2].
- Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; byte lane from addr[1:0], little-endian; sign/zero extend to WIDTH. Stores: 000 SB, 001 SH, 010 SW; only addressed byte lanes written. Other funct3: treated as LW/SW.
- Address bits above ADDR_W+1 ignored (wrap-around).
- Misaligned: half with addr[0]=1, word with addr[1:0]!=0.

## Timing
- MEM/WB outputs update on the edge ending the completion cycle (non-access: every non-stalled cycle); latency MEM->WB = 1 + LATENCY cycles for accesses, 1 otherwise.
- While Stall_M=1 each edge loads a bubble: RegWrite_W=0, ResultSrc_W=00, other W fields 0.
- Reset (asserted any time, incl. mid-WAIT): state IDLE, counter 0, all outputs 0, Stall_M=0, MisalignFault_M=0; pending store aborted, RAM not written; RAM contents not reset.
- Back-to-back accesses: completion cycle returns to IDLE; next access starts the following cycle, Stall_M re-asserts.
- MisalignFault_M combinational, asserted only on the completion cycle.

## Configuration
- LSU_MISALIGN_CHECK_EN defined: misaligned access detected; RAM write suppressed, MEM/WB loads a bubble (RegWrite_W=0), MisalignFault_M pulses 1 cycle; latency/stall unchanged.
- Not defined: no check; addr low bits forced to natural alignment (half: addr[0]=0, word: addr[1:0]=0), MisalignFault_M tied 0.

## Test plan
- LATENCY=0, SW 0xDEADBEEF @0x10 then LW @0x10 -> no Stall_M; ReadData_W=0xDEADBEEF, RegWrite_W=1 one edge after load.
- LATENCY=2, LW -> Stall_M high exactly 2 cycles, bubble in WB for 2 edges, load data on 3rd edge.
- Word 0x80FF7F01 @0x20: LB @0x23 -> 0xFFFFFF80; LBU @0x23 -> 0x00000080; LH @0x22 -> 0xFFFF80FF; SB 0xAA @0x21 then LW -> 0x80FFAA01.
- With LSU_MISALIGN_CHECK_EN, SW @0x22 -> RAM unchanged, MisalignFault_M 1-cycle pulse, RegWrite_W=0; without macro -> word stored @0x20, fault 0.
- LATENCY=2, assert rst_n=0 during WAIT of SW -> all outputs 0 immediately, subsequent LW shows old data.
- ADD (ResultSrc 00) and JAL (10) between loads -> no stall, ALUResult_W/PCP4_W pass through with 1-cycle latency.
